// File: rtl/exp_unit_pipe.sv
// Exponent datapath for the FP divide/sqrt/multiply unit.
// Takes one request at a time. It forms the pre-normalisation exponent,
// waits for the mantissa unit's normalisation decrement, and then returns
// a saturated final exponent with overflow/underflow flags.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | ready for a new request (in_ready=1)
// CALC     | form signed internal exponent eint and the sqrt shift
// WAIT_DEC | waiting for decrement from mantissa unit (dec_ready=1)
// DONE     | result presented (out_valid=1) until consumer takes it
module exp_unit_pipe #(
  parameter int WIDTH     = 8,
  parameter int DEC_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     e1,
  input  logic [WIDTH-1:0]     e2,
  output logic                 shift,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [DEC_WIDTH-1:0] decrement,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     e3,
  output logic                 ovf,
  output logic                 unf,
  output logic                 illegal
);

  // Three guard bits cover the worst-case sum or difference of two
  // biased exponents plus the bias, together with a sign bit.
  localparam int EW = WIDTH + 3;
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << WIDTH) - 1);
  localparam logic signed [EW-1:0] ZERO = '0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_SQRT = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_WAIT_DEC, S_DONE} state_t;

  state_t state, state_next;

  logic [1:0]           op_r;
  logic [WIDTH-1:0]     e1_r, e2_r;
  logic signed [EW-1:0] eint_r;

  logic signed [EW-1:0] e1_x, e2_x, u, sh_x, u_even, eint_calc, dec_x, ef;
  logic                 shift_calc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (in_valid) state_next = S_CALC;
      S_CALC:     state_next = (op_r == 2'b11) ? S_DONE : S_WAIT_DEC;
      S_WAIT_DEC: if (dec_valid) state_next = S_DONE;
      S_DONE:     if (out_ready) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == S_IDLE);
    dec_ready = (state == S_WAIT_DEC);
    out_valid = (state == S_DONE);
  end

  // Pre-normalisation exponent for the captured request
  always_comb begin
    e1_x       = {3'b000, e1_r};
    e2_x       = {3'b000, e2_r};
    u          = e1_x - BIAS;
    shift_calc = u[0];
    sh_x       = {{(EW-1){1'b0}}, shift_calc};
    u_even     = u - sh_x;
    eint_calc  = ZERO;
    case (op_r)
      OP_DIV:  eint_calc = e1_x - e2_x + BIAS;
      OP_SQRT: eint_calc = (u_even >>> 1) + BIAS;
      OP_MUL:  eint_calc = e1_x + e2_x - BIAS;
      default: eint_calc = ZERO;
    endcase
  end

  // Final exponent before saturation
  always_comb begin
    dec_x = {{(EW-DEC_WIDTH){1'b0}}, decrement};
    ef    = eint_r - dec_x;
  end

  // Datapath registers: request capture, CALC results and saturated output
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r    <= '0;
      e1_r    <= '0;
      e2_r    <= '0;
      eint_r  <= '0;
      shift   <= 1'b0;
      e3      <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_r <= op;
            e1_r <= e1;
            e2_r <= e2;
          end
        end
        S_CALC: begin
          eint_r <= eint_calc;
          if (op_r == 2'b11) begin
            illegal <= 1'b1;
            shift   <= 1'b0;
            e3      <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
          end else begin
            illegal <= 1'b0;
            shift   <= (op_r == OP_SQRT) ? shift_calc : 1'b0;
          end
        end
        S_WAIT_DEC: begin
          if (dec_valid) begin
            if (ef >= EMAX) begin
              e3  <= '1;
              ovf <= 1'b1;
              unf <= 1'b0;
            end else if (ef <= ZERO) begin
              e3  <= '0;
              ovf <= 1'b0;
              unf <= 1'b1;
            end else begin
              e3  <= ef[WIDTH-1:0];
              ovf <= 1'b0;
              unf <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_unit_pipe.sv
// Bench for exp_unit_pipe: directed vector table, handshake/reset
// sequences and randomized transactions against an arithmetic model.
module tb_exp_unit_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [1:0] op;
  logic [7:0] e1, e2, e3;
  logic       shift;
  logic       dec_valid, dec_ready;
  logic [0:0] decrement;
  logic       out_valid, out_ready;
  logic       ovf, unf, illegal;

  exp_unit_pipe #(.WIDTH(8), .DEC_WIDTH(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .e1(e1), .e2(e2), .shift(shift), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .decrement(decrement), .out_valid(out_valid),
    .out_ready(out_ready), .e3(e3), .ovf(ovf), .unf(unf), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int e3; int sh; int ovf; int unf; int ill;
  } res_t;

  typedef struct {
    int op; int e1; int e2; int dec; int dly; int hold;
    bit pulse; bit extra;
    int x_e3; int x_sh; int x_ovf; int x_unf; int x_ill;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exponent rules in plain integer arithmetic, bias 127.
  function automatic res_t model(input int p_op, input int p_e1, input int p_e2, input int p_dec);
    res_t r;
    int ef, u;
    r = '{default: 0};
    ef = 0;
    if (p_op == 3) begin
      r.ill = 1;
      return r;
    end
    case (p_op)
      0: ef = p_e1 - p_e2 + 127;
      2: ef = p_e1 + p_e2 - 127;
      default: begin
        u = p_e1 - 127;
        r.sh = (u % 2 != 0) ? 1 : 0;
        ef = (u - r.sh) / 2 + 127;
      end
    endcase
    ef = ef - p_dec;
    if (ef >= 255) begin r.e3 = 255; r.ovf = 1; end
    else if (ef <= 0) begin r.e3 = 0; r.unf = 1; end
    else r.e3 = ef;
    return r;
  endfunction

  task automatic start_req(input int p_op, input int p_e1, input int p_e2);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    chk("in_ready_before_req", in_ready, 1);
    in_valid = 1'b1; op = 2'(p_op); e1 = 8'(p_e1); e2 = 8'(p_e2);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_txn(input int p_op, input int p_e1, input int p_e2, input int p_dec,
                         input int p_dly, input int p_hold, input bit p_pulse, input bit p_extra,
                         output res_t got);
    int lat;
    got = '{default: 0};
    start_req(p_op, p_e1, p_e2);
    lat = 1;
    chk("dec_ready_in_calc", dec_ready, 0);
    chk("in_ready_in_calc", in_ready, 0);
    if (p_pulse) begin dec_valid = 1'b1; decrement = 1'b1; end
    @(posedge clk); #1; lat++;
    dec_valid = 1'b0;
    if (p_op != 3) begin
      chk("dec_ready_wait", dec_ready, 1);
      chk("out_valid_wait", out_valid, 0);
      repeat (p_dly) begin @(posedge clk); #1; lat++; end
      chk("dec_ready_held", dec_ready, 1);
      dec_valid = 1'b1; decrement = 1'(p_dec);
      @(posedge clk); #1; lat++;
      dec_valid = 1'b0;
    end else begin
      chk("no_dec_ready_illegal", dec_ready, 0);
    end
    chk("out_valid", out_valid, 1);
    chk("latency", lat, (p_op == 3) ? 2 : 3 + p_dly);
    got.e3 = int'(e3); got.sh = int'(shift); got.ovf = int'(ovf);
    got.unf = int'(unf); got.ill = int'(illegal);
    if (p_hold > 0) begin
      if (p_extra) begin in_valid = 1'b1; op = 2'b10; e1 = 8'd200; e2 = 8'd200; end
      repeat (p_hold) begin
        @(posedge clk); #1;
        chk("hold_out_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_e3", e3, got.e3);
        chk("hold_flags", {shift, ovf, unf, illegal},
            {1'(got.sh), 1'(got.ovf), 1'(got.unf), 1'(got.ill)});
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_fire", out_valid, 0);
    chk("in_ready_after_fire", in_ready, 1);
    if (p_extra) begin
      repeat (3) begin
        @(posedge clk); #1;
        chk("extra_not_queued", {in_ready, dec_ready, out_valid}, 3'b100);
      end
    end
  endtask

  task automatic cmp_res(input string tag, input res_t got, input res_t exp);
    chk({tag, "_e3"}, got.e3, exp.e3);
    chk({tag, "_shift"}, got.sh, exp.sh);
    chk({tag, "_ovf"}, got.ovf, exp.ovf);
    chk({tag, "_unf"}, got.unf, exp.unf);
    chk({tag, "_illegal"}, got.ill, exp.ill);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_dec_ready"}, dec_ready, 0);
    chk({tag, "_e3"}, e3, 0);
    chk({tag, "_flags"}, {shift, ovf, unf, illegal}, 4'b0000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    res_t got, exp;
    int r_op, r_e1, r_e2, r_dec;

    reset = 1'b1; in_valid = 1'b0; op = '0; e1 = '0; e2 = '0;
    dec_valid = 1'b0; decrement = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    reset = 1'b0;

    //                 op  e1   e2  dec dly hold pulse extra  e3  sh ovf unf ill
    vecs.push_back(vec_t'{0, 130, 127, 1, 0, 0, 1'b0, 1'b0, 129, 0, 0, 0, 0});
    vecs.push_back(vec_t'{2, 200, 200, 0, 0, 0, 1'b0, 1'b0, 255, 0, 1, 0, 0});
    vecs.push_back(vec_t'{0,   1, 200, 0, 0, 0, 1'b0, 1'b0,   0, 0, 0, 1, 0});
    vecs.push_back(vec_t'{1, 128, 200, 0, 0, 0, 1'b0, 1'b0, 127, 1, 0, 0, 0});
    vecs.push_back(vec_t'{1, 129,  17, 0, 0, 0, 1'b0, 1'b0, 128, 0, 0, 0, 0});
    vecs.push_back(vec_t'{1,   1,  99, 0, 0, 0, 1'b0, 1'b0,  64, 0, 0, 0, 0});
    vecs.push_back(vec_t'{1, 129,   0, 1, 0, 0, 1'b0, 1'b0, 127, 0, 0, 0, 0});
    vecs.push_back(vec_t'{3,   5,   6, 0, 0, 0, 1'b0, 1'b0,   0, 0, 0, 0, 1});
    vecs.push_back(vec_t'{0, 255, 127, 0, 0, 0, 1'b0, 1'b0, 255, 0, 1, 0, 0});
    vecs.push_back(vec_t'{0, 255, 127, 1, 0, 0, 1'b0, 1'b0, 254, 0, 0, 0, 0});
    vecs.push_back(vec_t'{2,  63,  64, 0, 0, 0, 1'b0, 1'b0,   0, 0, 0, 1, 0});
    vecs.push_back(vec_t'{2,  64,  64, 0, 0, 0, 1'b0, 1'b0,   1, 0, 0, 0, 0});
    vecs.push_back(vec_t'{1,   0,   0, 0, 0, 0, 1'b0, 1'b0,  63, 1, 0, 0, 0});
    vecs.push_back(vec_t'{1, 255,   3, 0, 0, 0, 1'b0, 1'b0, 191, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0, 130, 127, 0, 5, 4, 1'b1, 1'b1, 130, 0, 0, 0, 0});
    vecs.push_back(vec_t'{2,   1,   1, 1, 1, 2, 1'b0, 1'b0,   0, 0, 0, 1, 0});

    foreach (vecs[i]) begin
      run_txn(vecs[i].op, vecs[i].e1, vecs[i].e2, vecs[i].dec, vecs[i].dly,
              vecs[i].hold, vecs[i].pulse, vecs[i].extra, got);
      exp = '{vecs[i].x_e3, vecs[i].x_sh, vecs[i].x_ovf, vecs[i].x_unf, vecs[i].x_ill};
      cmp_res($sformatf("vec%0d", i), got, exp);
    end

    // Reset while waiting for the decrement; flags left high by the previous result.
    run_txn(2, 200, 200, 0, 0, 0, 1'b0, 1'b0, got);
    start_req(0, 130, 127);
    @(posedge clk); #1;
    chk("rst_wait_dec_ready", dec_ready, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_state("rst_wait");
    dec_valid = 1'b1; decrement = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_wait_discarded", {in_ready, dec_ready, out_valid}, 3'b100);
    end
    dec_valid = 1'b0;
    run_txn(0, 130, 127, 0, 0, 0, 1'b0, 1'b0, got);
    cmp_res("after_rst_wait", got, '{130, 0, 0, 0, 0});

    // Reset while the result is presented (sqrt with shift=1 pending).
    start_req(1, 128, 0);
    @(posedge clk); #1;
    dec_valid = 1'b1; decrement = 1'b0;
    @(posedge clk); #1;
    dec_valid = 1'b0;
    chk("rst_done_out_valid", out_valid, 1);
    chk("rst_done_shift", shift, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_state("rst_done");
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_done_discarded", {in_ready, out_valid}, 2'b10);
    end
    out_ready = 1'b0;
    run_txn(0, 130, 127, 0, 0, 0, 1'b0, 1'b0, got);
    cmp_res("after_rst_done", got, '{130, 0, 0, 0, 0});

    // Randomized transactions against the model.
    for (int n = 0; n < 60; n++) begin
      r_op  = int'($urandom_range(0, 3));
      r_e1  = int'($urandom_range(0, 255));
      r_e2  = int'($urandom_range(0, 255));
      r_dec = int'($urandom_range(0, 1));
      run_txn(r_op, r_e1, r_e2, r_dec, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0, got);
      cmp_res($sformatf("rand%0d", n), got, model(r_op, r_e1, r_e2, r_dec));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
